// File: rtl/otbn_pq_pkg.sv
// Shared types for the OTBN-PQ twiddle/root computation unit.
// Build option: OTBN_PQ_TRCU_PSI_EN enables the psi bank and its ops.
package otbn_pq_pkg;

    typedef enum logic [2:0] {
        OpUpdTwiddle  = 3'd0,
        OpUpdOmega    = 3'd1,
        OpUpdPsi      = 3'd2,
        OpSetTwPsi    = 3'd3,
        OpInvTwiddle  = 3'd4,
        OpOmegaIdxInc = 3'd5,
        OpPsiIdxInc   = 3'd6,
        OpReserved    = 3'd7
    } trcu_op_e;

    typedef enum logic [2:0] {
        WrTwiddle  = 3'd0,
        WrOmega    = 3'd1,
        WrPsi      = 3'd2,
        WrOmegaIdx = 3'd3,
        WrPsiIdx   = 3'd4,
        WrRsvd5    = 3'd5,
        WrRsvd6    = 3'd6,
        WrRsvd7    = 3'd7
    } trcu_wr_sel_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StRed  = 2'd2,
        StFin  = 2'd3
    } trcu_state_e;

`ifdef OTBN_PQ_TRCU_PSI_EN
    localparam bit PsiEn = 1'b1;
`else
    localparam bit PsiEn = 1'b0;
`endif

endpackage

// File: rtl/otbn_pq_mont_mul.sv
// Three-stage Montgomery multiplier: product, reduction, final conditional subtract.
// Operands and constants are captured on start_i; res_o is valid two cycles later.
module otbn_pq_mont_mul #(
    parameter int DataW = 32,
    parameter int LogR  = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  logic [DataW-1:0] q_i,
    input  logic [LogR-1:0]  qd_i,
    output logic [DataW-1:0] res_o
);

    localparam int SumW = LogR + DataW + 1;

    logic [DataW-1:0]   a_q, b_q, q_q;
    logic [LogR-1:0]    qd_q;
    logic [2*DataW-1:0] t_q;
    logic [DataW:0]     u_q, u_d;
    logic [1:0]         stg_q;
    logic [SumW-1:0]    t_ext, sum;
    logic [LogR-1:0]    t_lo, m;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            q_q   <= '0;
            qd_q  <= '0;
            t_q   <= '0;
            u_q   <= '0;
            stg_q <= '0;
        end else begin
            stg_q <= {stg_q[0], start_i};
            if (start_i) begin
                a_q  <= a_i;
                b_q  <= b_i;
                q_q  <= q_i;
                qd_q <= qd_i;
            end
            if (stg_q[0]) t_q <= (2*DataW)'(a_q) * (2*DataW)'(b_q);
            if (stg_q[1]) u_q <= u_d;
        end
    end

    // m only needs the low LogR bits, so the multiply is done at that width
    always_comb begin
        t_ext = SumW'(t_q);
        t_lo  = LogR'(t_ext);
        m     = t_lo * qd_q;
        sum   = t_ext + SumW'(m) * SumW'(q_q);
        u_d   = (DataW+1)'(sum >> LogR);
    end

    assign res_o = (u_q >= {1'b0, q_q}) ? DataW'(u_q - {1'b0, q_q}) : DataW'(u_q);

endmodule

// File: rtl/otbn_pq_trcu.sv
// Twiddle/root computation unit: FSM, root banks, index counters, handshake and errors.
// Build option: OTBN_PQ_TRCU_PSI_EN enables the psi bank, psi_idx and ops 2, 3, 6.
module otbn_pq_trcu
    import otbn_pq_pkg::*;
#(
    parameter int DataW  = 32,
    parameter int LogR   = 32,
    parameter int NLanes = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      op_valid_i,
    output logic                      op_ready_o,
    input  trcu_op_e                  op_i,
    input  logic [DataW-1:0]          prime_i,
    input  logic [LogR-1:0]           prime_dash_i,
    input  logic                      wr_en_i,
    input  trcu_wr_sel_e              wr_sel_i,
    input  logic [$clog2(NLanes)-1:0] wr_lane_i,
    input  logic [DataW-1:0]          wr_data_i,
    output logic [DataW-1:0]          twiddle_o,
    output logic [DataW-1:0]          omega_o,
    output logic [DataW-1:0]          psi_o,
    output logic [$clog2(NLanes)-1:0] omega_idx_o,
    output logic [$clog2(NLanes)-1:0] psi_idx_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int IdxW = $clog2(NLanes);

    trcu_state_e      state_q, state_d;
    trcu_op_e         op_q;
    logic [DataW-1:0] twiddle_q;
    logic [DataW-1:0] omega_q [NLanes];
    logic [IdxW-1:0]  omega_idx_q;
    logic [DataW-1:0] omega_cur, psi_cur;
    logic [IdxW-1:0]  psi_idx;
    logic             done_q, err_q;
    logic             op_legal, op_is_mont, wr_legal;
    logic             accept, accept_mont, accept_single, wr_do, idle;
    logic             mont_start;
    logic [DataW-1:0] mont_a, mont_b, mont_res;

    assign idle          = (state_q == StIdle);
    assign op_ready_o    = idle && !wr_en_i;
    assign accept        = op_valid_i && op_ready_o;
    assign accept_mont   = accept && op_legal && op_is_mont;
    assign accept_single = accept && op_legal && !op_is_mont;
    assign wr_do         = wr_en_i && idle && wr_legal;
    assign omega_cur     = omega_q[omega_idx_q];

    always_comb begin
        op_legal   = 1'b0;
        op_is_mont = 1'b0;
        case (op_i)
            OpUpdTwiddle, OpUpdOmega: begin
                op_legal   = 1'b1;
                op_is_mont = 1'b1;
            end
            OpUpdPsi: begin
                op_legal   = PsiEn;
                op_is_mont = 1'b1;
            end
            OpSetTwPsi, OpPsiIdxInc:     op_legal = PsiEn;
            OpInvTwiddle, OpOmegaIdxInc: op_legal = 1'b1;
            default:                     op_legal = 1'b0;
        endcase
    end

    always_comb begin
        wr_legal = 1'b0;
        case (wr_sel_i)
            WrTwiddle, WrOmega, WrOmegaIdx: wr_legal = 1'b1;
            WrPsi, WrPsiIdx:                wr_legal = PsiEn;
            default:                        wr_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mont_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept_mont) begin
                    state_d    = StMul;
                    mont_start = 1'b1;
                end
            end
            StMul:   state_d = StRed;
            StRed:   state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mont_a = twiddle_q;
        mont_b = omega_cur;
        case (op_i)
            OpUpdOmega: mont_a = omega_cur;
            OpUpdPsi: begin
                mont_a = psi_cur;
                mont_b = psi_cur;
            end
            default: ;
        endcase
    end

    otbn_pq_mont_mul #(
        .DataW(DataW),
        .LogR (LogR)
    ) u_mont_mul (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(mont_start),
        .a_i    (mont_a),
        .b_i    (mont_b),
        .q_i    (prime_i),
        .qd_i   (prime_dash_i),
        .res_o  (mont_res)
    );

    // Fin writeback, idle direct writes and single-cycle ops never coincide
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            twiddle_q   <= '0;
            omega_idx_q <= '0;
            op_q        <= OpUpdTwiddle;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NLanes; i++) omega_q[i] <= '0;
        end else begin
            done_q <= accept_single || (state_q == StFin);
            err_q  <= (accept && !op_legal) || (wr_en_i && !idle) ||
                      (wr_en_i && idle && !wr_legal);
            if (accept_mont) op_q <= op_i;
            if (state_q == StFin) begin
                case (op_q)
                    OpUpdTwiddle: twiddle_q <= mont_res;
                    OpUpdOmega:   omega_q[omega_idx_q] <= mont_res;
                    default: ;
                endcase
            end
            if (wr_do) begin
                case (wr_sel_i)
                    WrTwiddle:  twiddle_q <= wr_data_i;
                    WrOmega:    omega_q[wr_lane_i] <= wr_data_i;
                    WrOmegaIdx: omega_idx_q <= IdxW'(wr_data_i);
                    default: ;
                endcase
            end
            if (accept_single) begin
                case (op_i)
                    OpSetTwPsi:    twiddle_q <= psi_cur;
                    OpInvTwiddle:  twiddle_q <= (twiddle_q == '0) ? '0 : prime_i - twiddle_q;
                    OpOmegaIdxInc: omega_idx_q <= omega_idx_q + IdxW'(1);
                    default: ;
                endcase
            end
        end
    end

`ifdef OTBN_PQ_TRCU_PSI_EN
    logic [DataW-1:0] psi_q [NLanes];
    logic [IdxW-1:0]  psi_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psi_idx_q <= '0;
            for (int i = 0; i < NLanes; i++) psi_q[i] <= '0;
        end else begin
            if (state_q == StFin && op_q == OpUpdPsi) psi_q[psi_idx_q] <= mont_res;
            if (wr_do && wr_sel_i == WrPsi)           psi_q[wr_lane_i] <= wr_data_i;
            if (wr_do && wr_sel_i == WrPsiIdx)        psi_idx_q <= IdxW'(wr_data_i);
            if (accept_single && op_i == OpPsiIdxInc) psi_idx_q <= psi_idx_q + IdxW'(1);
        end
    end

    assign psi_cur = psi_q[psi_idx_q];
    assign psi_idx = psi_idx_q;
`else
    assign psi_cur = '0;
    assign psi_idx = '0;
`endif

    assign twiddle_o   = twiddle_q;
    assign omega_o     = omega_cur;
    assign psi_o       = psi_cur;
    assign omega_idx_o = omega_idx_q;
    assign psi_idx_o   = psi_idx;
    assign busy_o      = !idle;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_otbn_pq_trcu.sv
// Self-checking bench for otbn_pq_trcu with a result scoreboard filled at issue time.
// Works in both builds; psi-specific expectations follow OTBN_PQ_TRCU_PSI_EN.
module tb_otbn_pq_trcu;
    import otbn_pq_pkg::*;

    localparam int DataW  = 32;
    localparam int LogR   = 32;
    localparam int NLanes = 8;
    localparam int IdxW   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             op_valid;
    logic             op_ready;
    trcu_op_e         op;
    logic [DataW-1:0] prime;
    logic [LogR-1:0]  prime_dash;
    logic             wr_en;
    trcu_wr_sel_e     wr_sel;
    logic [IdxW-1:0]  wr_lane;
    logic [DataW-1:0] wr_data;
    logic [DataW-1:0] twiddle_o, omega_o, psi_o;
    logic [IdxW-1:0]  omega_idx_o, psi_idx_o;
    logic             busy_o, done_o, err_o;

    always #5 clk = ~clk;

    otbn_pq_trcu #(
        .DataW (DataW),
        .LogR  (LogR),
        .NLanes(NLanes)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .op_i        (op),
        .prime_i     (prime),
        .prime_dash_i(prime_dash),
        .wr_en_i     (wr_en),
        .wr_sel_i    (wr_sel),
        .wr_lane_i   (wr_lane),
        .wr_data_i   (wr_data),
        .twiddle_o   (twiddle_o),
        .omega_o     (omega_o),
        .psi_o       (psi_o),
        .omega_idx_o (omega_idx_o),
        .psi_idx_o   (psi_idx_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    typedef struct {
        string           tag;
        logic [31:0]     tw;
        logic [31:0]     om;
        logic [IdxW-1:0] oi;
    } sb_entry_t;

    sb_entry_t       sb[$];
    sb_entry_t       popped;
    int              testsRun = 0;
    int              testsFailed = 0;
    longint unsigned q = 3329;
    longint unsigned rInv;
    logic [31:0]     qInv;
    logic [31:0]     qd;
    logic [31:0]     mTw;
    logic [31:0]     mOm[NLanes];
    logic [IdxW-1:0] mOi;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference via plain modular arithmetic: a*b*R^-1 mod q
    function automatic logic [31:0] modelMont(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        p = (64'(a) * 64'(b)) % q;
        return 32'((p * rInv) % q);
    endfunction

    function automatic bit benchLegal(input trcu_op_e o);
`ifdef OTBN_PQ_TRCU_PSI_EN
        return (o != OpReserved);
`else
        return (o == OpUpdTwiddle) || (o == OpUpdOmega) ||
               (o == OpInvTwiddle) || (o == OpOmegaIdxInc);
`endif
    endfunction

    function automatic bit benchLegalSel(input trcu_wr_sel_e s);
`ifdef OTBN_PQ_TRCU_PSI_EN
        return (s == WrTwiddle) || (s == WrOmega) || (s == WrOmegaIdx) ||
               (s == WrPsi) || (s == WrPsiIdx);
`else
        return (s == WrTwiddle) || (s == WrOmega) || (s == WrOmegaIdx);
`endif
    endfunction

    // Drives one op for a single cycle; returns at the cycle-1 sample point
    task automatic applyStimulus(input trcu_op_e o, input bit commit, input string tag);
        op_valid = 1'b1;
        op       = o;
        if (commit && benchLegal(o)) begin
            case (o)
                OpUpdTwiddle:  mTw = modelMont(mTw, mOm[mOi]);
                OpUpdOmega:    mOm[mOi] = modelMont(mOm[mOi], mOm[mOi]);
                OpSetTwPsi:    mTw = 32'd0;
                OpInvTwiddle:  mTw = (mTw == 32'd0) ? 32'd0 : 32'(q) - mTw;
                OpOmegaIdxInc: mOi = mOi + 3'd1;
                default: ;
            endcase
            sb.push_back('{tag, mTw, mOm[mOi], mOi});
        end
        @(negedge clk);
        op_valid = 1'b0;
        op       = OpUpdTwiddle;
    endtask

    task automatic writeReg(input trcu_wr_sel_e s, input logic [IdxW-1:0] lane, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_lane = lane;
        wr_data = data;
        if (benchLegalSel(s)) begin
            case (s)
                WrTwiddle:  mTw = data;
                WrOmega:    mOm[lane] = data;
                WrOmegaIdx: mOi = data[IdxW-1:0];
                default: ;
            endcase
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                popped = sb.pop_front();
                checkOutput({popped.tag, "_tw"}, twiddle_o, popped.tw);
                checkOutput({popped.tag, "_om"}, omega_o, popped.om);
                checkOutput({popped.tag, "_oi"}, 32'(omega_idx_o), 32'(popped.oi));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint unsigned rMod;
        rst_n      = 1'b0;
        op_valid   = 1'b0;
        op         = OpUpdTwiddle;
        wr_en      = 1'b0;
        wr_sel     = WrTwiddle;
        wr_lane    = '0;
        wr_data    = '0;
        prime      = 32'(q);
        mTw        = '0;
        mOi        = '0;
        for (int i = 0; i < NLanes; i++) mOm[i] = '0;

        qInv = 32'(q);
        repeat (5) qInv = qInv * (32'd2 - 32'(q) * qInv);
        qd         = ~qInv + 32'd1;
        prime_dash = qd;
        rMod = (64'd1 << 32) % q;
        rInv = 0;
        for (longint unsigned x = 1; x < q; x++) if ((rMod * x) % q == 1) rInv = x;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_twiddle", twiddle_o, 32'd0);
        checkOutput("rst_omega", omega_o, 32'd0);
        checkOutput("rst_psi", psi_o, 32'd0);
        checkOutput("rst_idx", 32'({omega_idx_o, psi_idx_o}), 32'd0);
        checkOutput("rst_flags", 32'({busy_o, done_o, err_o}), 32'd0);
        checkOutput("rst_ready", 32'(op_ready), 32'd1);
        wr_en = 1'b1;
        #1 checkOutput("rst_ready_wr", 32'(op_ready), 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Montgomery one
        writeReg(WrTwiddle, 3'd0, 32'(rMod));
        writeReg(WrOmega, 3'd0, 32'd17);
        checkOutput("wr_no_done", 32'(done_o), 32'd0);
        applyStimulus(OpUpdTwiddle, 1'b1, "mont_one");
        checkOutput("mont_busy_c1", 32'({busy_o, done_o}), 32'b10);
        @(negedge clk);
        checkOutput("mont_busy_c2", 32'(busy_o), 32'd1);
        @(negedge clk);
        checkOutput("mont_busy_c3", 32'({busy_o, done_o}), 32'b10);
        @(negedge clk);
        checkOutput("mont_c4_flags", 32'({busy_o, done_o, op_ready}), 32'b011);
        checkOutput("mont_one_val", twiddle_o, 32'd17);

        // Negation
        applyStimulus(OpInvTwiddle, 1'b1, "neg17");
        checkOutput("neg17_val", twiddle_o, 32'd3312);
        checkOutput("neg17_done", 32'(done_o), 32'd1);
        writeReg(WrTwiddle, 3'd0, 32'd0);
        applyStimulus(OpInvTwiddle, 1'b1, "neg0");
        checkOutput("neg0_val", twiddle_o, 32'd0);

        // Index wrap
        for (int i = 0; i < NLanes; i++) writeReg(WrOmega, 3'(i), 32'(100 + 7 * i));
        writeReg(WrOmegaIdx, 3'd0, 32'd7);
        checkOutput("idx7_omega", omega_o, 32'd149);
        applyStimulus(OpOmegaIdxInc, 1'b1, "wrap");
        checkOutput("wrap_idx", 32'(omega_idx_o), 32'd0);
        checkOutput("wrap_omega", omega_o, 32'd100);

        // Busy write
        writeReg(WrTwiddle, 3'd0, 32'd555);
        applyStimulus(OpUpdOmega, 1'b1, "busywr");
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = WrTwiddle;
        wr_data = 32'd999;
        @(negedge clk);
        wr_en = 1'b0;
        checkOutput("busywr_err", 32'(err_o), 32'd1);
        checkOutput("busywr_tw", twiddle_o, 32'd555);
        @(negedge clk);
        checkOutput("busywr_c4", 32'({done_o, err_o}), 32'b10);
        checkOutput("busywr_om", omega_o, modelMont(32'd100, 32'd100));

        // Illegal ops and write target
        checkOutput("rsvd_ready_pre", 32'(op_ready), 32'd1);
        applyStimulus(OpReserved, 1'b1, "rsvd");
        checkOutput("rsvd_flags", 32'({err_o, done_o, op_ready}), 32'b101);
`ifndef OTBN_PQ_TRCU_PSI_EN
        applyStimulus(OpUpdPsi, 1'b1, "psi_off");
        checkOutput("psi_off_flags", 32'({err_o, done_o, op_ready, busy_o}), 32'b1010);
        @(negedge clk);
        checkOutput("psi_off_idle", 32'({busy_o, done_o}), 32'b00);
`endif
        writeReg(WrRsvd5, 3'd0, 32'd123);
        checkOutput("wrsel5_err", 32'(err_o), 32'd1);
        checkOutput("wrsel5_tw", twiddle_o, mTw);

        // Reset abort mid-op
        applyStimulus(OpUpdTwiddle, 1'b0, "abort");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_tw", twiddle_o, 32'd0);
        checkOutput("abort_om", omega_o, 32'd0);
        checkOutput("abort_flags", 32'({busy_o, done_o, err_o}), 32'b000);
        mTw = '0;
        mOi = '0;
        for (int i = 0; i < NLanes; i++) mOm[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_no_done", 32'(done_o), 32'd0);

        // Fresh op after reset; constants change mid-op
        writeReg(WrTwiddle, 3'd0, 32'd2000);
        writeReg(WrOmega, 3'd0, 32'd1234);
        applyStimulus(OpUpdTwiddle, 1'b1, "fresh");
        @(negedge clk);
        prime      = 32'd7;
        prime_dash = 32'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("fresh_done", 32'(done_o), 32'd1);
        checkOutput("fresh_val", twiddle_o, modelMont(32'd2000, 32'd1234));
        prime      = 32'(q);
        prime_dash = qd;
        @(negedge clk);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
